// File: rtl/store_grid_pkg.sv
// Shared types and helpers for the store_grid storage array.
package store_grid_pkg;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_SHIFT = 1'b1
  } rd_state_e;

  // Flat bit position of the cell at (row r, column c).
  function automatic int cell_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/store_grid_serializer.sv
// Snapshot-based serial readout of the parallel array contents.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RD_IDLE  | waiting for rd_start; snapshot loads on the accepting edge
// RD_SHIFT | one snapshot bit per cycle, index 0 first; done on the last
module store_grid_serializer
  import store_grid_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rd_start,
  input  logic [N-1:0] pdat,
  output logic         rd_busy,
  output logic         rd_valid,
  output logic         rd_bit,
  output logic         rd_done
);

  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  rd_state_e     state_q, state_d;
  logic [N-1:0]  snap_q;
  logic [IW-1:0] idx_q;
  logic          last;

  assign last     = (idx_q == IDX_LAST);
  assign rd_valid = rd_busy;

  // Next-state and decoded status outputs.
  always_comb begin
    state_d = state_q;
    rd_busy = 1'b0;
    rd_done = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rd_start) state_d = RD_SHIFT;
      end
      RD_SHIFT: begin
        rd_busy = 1'b1;
        if (last) begin
          rd_done = 1'b1;
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // State, snapshot, index and the registered serial bit (pre-fetched one cycle ahead).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RD_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      rd_bit  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RD_IDLE) begin
        if (rd_start) begin
          snap_q <= pdat;
          idx_q  <= '0;
          rd_bit <= pdat[0];
        end
      end else if (last) begin
        idx_q  <= '0;
        rd_bit <= 1'b0;
      end else begin
        idx_q  <= idx_q + IW'(1);
        rd_bit <= snap_q[idx_q + IW'(1)];
      end
    end
  end

endmodule

// File: rtl/store_grid.sv
// ROWSxCOLS flop array with column capture, sync clear, sticky address error and serial readout.
module store_grid
  import store_grid_pkg::*;
#(
  parameter  int ROWS = 2,
  parameter  int COLS = 2,
  localparam int N    = ROWS * COLS,
  localparam int CW   = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] dat,
  input  logic            cap_en,
  input  logic [CW-1:0]   cap_col,
  input  logic            clear,
  output logic [N-1:0]    out,
  output logic            err,
  input  logic            rd_start,
  output logic            rd_busy,
  output logic            rd_valid,
  output logic            rd_bit,
  output logic            rd_done
);

  logic [N-1:0] cells_q, cells_d;
  logic         col_ok;

  assign col_ok = (int'(cap_col) < COLS);
  assign out    = cells_q;

  // Next array contents: clear wins over capture; an out-of-range column writes nothing.
  always_comb begin
    cells_d = cells_q;
    if (clear) begin
      cells_d = '0;
    end else if (cap_en && col_ok) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (c == int'(cap_col)) cells_d[cell_idx(r, c, COLS)] = dat[r];
        end
      end
    end
  end

  // Cell array and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells_q <= '0;
      err     <= 1'b0;
    end else begin
      cells_q <= cells_d;
      if (clear)                 err <= 1'b0;
      else if (cap_en && !col_ok) err <= 1'b1;
    end
  end

  store_grid_serializer #(.N(N)) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_start (rd_start),
    .pdat     (cells_q),
    .rd_busy  (rd_busy),
    .rd_valid (rd_valid),
    .rd_bit   (rd_bit),
    .rd_done  (rd_done)
  );

endmodule
